// File: rtl/idma_axis_framer_pkg.sv
// Shared types and helpers for the iDMA AXI-Stream TLAST framer.
package idma_axis_framer_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Widest keep mask the popcount helper handles (DataWidth up to 1024).
    localparam int unsigned MaxStrbWidth = 128;
    localparam int unsigned PopcntWidth  = $clog2(MaxStrbWidth) + 1;

    // Number of valid bytes in a keep mask; callers zero-extend narrower masks.
    function automatic logic [PopcntWidth-1:0] keep_popcount(input logic [MaxStrbWidth-1:0] strb);
        logic [PopcntWidth-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MaxStrbWidth; i++) begin
            cnt = cnt + PopcntWidth'(strb[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/idma_axis_tlast_framer_out_reg.sv
// One-deep registered output stage: accepts a new word whenever it is empty or
// its current word is being taken downstream in the same cycle.
module idma_axis_tlast_framer_out_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Hold the word until downstream takes it; reload on every accepted input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (in_ready_o) begin
                valid_q <= in_valid_i;
            end
            if (in_valid_i && in_ready_o) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/idma_axis_tlast_framer.sv
// Regenerates TLAST on the AXI-Stream write port of iDMA from the per-transfer
// byte lengths seen on the frontend->backend request handshake.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no transfer loaded; input stalled, queued lengths consumed
//  ACTIVE  | rem_q bytes left in the current transfer; beats forwarded
module idma_axis_tlast_framer
    import idma_axis_framer_pkg::*;
#(
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned StrbWidth    = DataWidth / 8,
    parameter int unsigned TFLenWidth   = 24,
    parameter int unsigned LenFifoDepth = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [TFLenWidth-1:0] len_i,
    input  logic                  len_valid_i,
    output logic                  len_ready_o,
    input  logic [DataWidth-1:0]  s_tdata_i,
    input  logic [StrbWidth-1:0]  s_tkeep_i,
    input  logic                  s_tvalid_i,
    output logic                  s_tready_o,
    output logic [DataWidth-1:0]  m_tdata_o,
    output logic [StrbWidth-1:0]  m_tkeep_o,
    output logic                  m_tlast_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int unsigned PtrW  = $clog2(LenFifoDepth);
    localparam int unsigned CntW  = $clog2(StrbWidth) + 1;
    localparam int unsigned BeatW = DataWidth + StrbWidth + 1;

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_ACTIVE = ACTIVE;

    // Length queue
    logic [TFLenWidth-1:0] len_mem [LenFifoDepth];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]         fill_q;
    logic                  fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [TFLenWidth-1:0] fifo_head;

    // FSM / byte counter
    logic [0:0]            state_q, state_d;
    logic [TFLenWidth-1:0] rem_q, rem_d;
    logic                  err_q;
    logic                  active;
    logic                  beat_acc, beat_last, beat_err;
    logic [CntW-1:0]       beat_cnt;
    logic [TFLenWidth-1:0] beat_len;

    // Output stage
    logic                  out_in_ready;
    logic                  out_valid;
    logic [BeatW-1:0]      out_data;

    assign fifo_empty  = (fill_q == '0);
    assign fifo_full   = (fill_q == (PtrW+1)'(LenFifoDepth));
    assign fifo_push   = len_valid_i & ~fifo_full;
    assign fifo_head   = len_mem[rd_ptr_q];
    assign len_ready_o = ~fifo_full;

    assign active     = (state_q == ST_ACTIVE);
    assign s_tready_o = active & out_in_ready;
    assign beat_acc   = s_tvalid_i & s_tready_o;
    assign beat_cnt   = CntW'(keep_popcount(MaxStrbWidth'(s_tkeep_i)));
    assign beat_len   = TFLenWidth'(beat_cnt);

    // Queue storage; only the head entry is ever read, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            len_mem[wr_ptr_q] <= len_i;
        end
    end

    // Queue pointers and fill level; the head is only read from storage, so a
    // length pushed this cycle becomes visible next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fill_q <= fill_q + (PtrW+1)'(1);
                2'b01:   fill_q <= fill_q - (PtrW+1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Next-state, remaining-byte and TLAST/overrun decisions.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        fifo_pop  = 1'b0;
        beat_last = 1'b0;
        beat_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_head != '0) begin
                        rem_d   = fifo_head;
                        state_d = ST_ACTIVE;
                    end
                end
            end
            default: begin
                if (beat_acc) begin
                    if (beat_len < rem_q) begin
                        // keep==0 beats land here too and leave rem unchanged
                        rem_d = rem_q - beat_len;
                    end else begin
                        beat_last = 1'b1;
                        beat_err  = (beat_len > rem_q);
                        if (!fifo_empty && (fifo_head != '0)) begin
                            // chain straight into the next transfer, no bubble
                            fifo_pop = 1'b1;
                            rem_d    = fifo_head;
                        end else begin
                            rem_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
        endcase
    end

    // FSM state, byte counter and the registered overrun pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            err_q   <= beat_err;
        end
    end

    idma_axis_tlast_framer_out_reg #(
        .Width (BeatW)
    ) i_out_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (s_tvalid_i & active),
        .in_ready_o  (out_in_ready),
        .in_data_i   ({s_tdata_i, s_tkeep_i, beat_last}),
        .out_valid_o (out_valid),
        .out_ready_i (m_tready_i),
        .out_data_o  (out_data)
    );

    assign {m_tdata_o, m_tkeep_o, m_tlast_o} = out_data;
    assign m_tvalid_o = out_valid;
    assign err_o      = err_q;
    assign busy_o     = ~fifo_empty | active | out_valid;

endmodule

// File: tb/tb_idma_axis_tlast_framer.sv
// Bench for idma_axis_tlast_framer: directed scenarios plus a randomized run,
// checked against a transfer-level byte-accounting model.
module tb_idma_axis_tlast_framer;

    localparam int DW = 64;
    localparam int SW = 8;
    localparam int LW = 24;

    typedef logic [DW+SW:0] beat_t; // {data, keep, last}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] len = '0;
    logic          len_valid = 1'b0;
    logic          len_ready;
    logic [DW-1:0] s_tdata = '0;
    logic [SW-1:0] s_tkeep = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tkeep;
    logic          m_tlast, m_tvalid;
    logic          m_tready = 1'b1;
    logic          busy, err;
    beat_t         cur_out;

    int checks = 0;
    int failures = 0;

    // scoreboard / model state
    beat_t         obs_q[$];
    beat_t         exp_q[$];
    int            obs_cyc_q[$];
    int            acc_cyc_q[$];
    logic [LW-1:0] mdl_len_q[$];
    int            mdl_sent = 0;
    int            cyc = 0;
    int            push_cyc = 0;
    int            err_viol = 0, lat_viol = 0, stab_viol = 0, mdl_viol = 0, len_viol = 0, err_pulses = 0;
    logic          prev_acc = 1'b0, prev_err = 1'b0, prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    beat_t         prev_out = '0;

    idma_axis_tlast_framer #(
        .DataWidth    (DW),
        .TFLenWidth   (LW),
        .LenFifoDepth (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .len_i       (len),
        .len_valid_i (len_valid),
        .len_ready_o (len_ready),
        .s_tdata_i   (s_tdata),
        .s_tkeep_i   (s_tkeep),
        .s_tvalid_i  (s_tvalid),
        .s_tready_o  (s_tready),
        .m_tdata_o   (m_tdata),
        .m_tkeep_o   (m_tkeep),
        .m_tlast_o   (m_tlast),
        .m_tvalid_o  (m_tvalid),
        .m_tready_i  (m_tready),
        .busy_o      (busy),
        .err_o       (err)
    );

    assign cur_out = {m_tdata, m_tkeep, m_tlast};

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor and model: every accepted beat is charged against the oldest
    // non-zero queued length; the beat closing a transfer carries TLAST and
    // flags an overrun when the running byte total exceeds the length.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            obs_q.delete(); exp_q.delete(); mdl_len_q.delete();
            obs_cyc_q.delete(); acc_cyc_q.delete();
            mdl_sent = 0;
            prev_acc = 1'b0; prev_err = 1'b0; prev_stall = 1'b0;
        end else begin
            if (err !== prev_err) err_viol++;
            if (err === 1'b1) err_pulses++;
            if (prev_acc && (m_tvalid !== 1'b1 || m_tdata !== prev_data)) lat_viol++;
            if (prev_stall && (m_tvalid !== 1'b1 || cur_out !== prev_out)) stab_viol++;
            if (m_tvalid && m_tready) begin
                obs_q.push_back(cur_out);
                obs_cyc_q.push_back(cyc);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_out   = cur_out;
            if (len_valid && !len_ready) len_viol++;
            if (len_valid && len_ready) begin
                mdl_len_q.push_back(len);
                push_cyc = cyc;
            end
            prev_acc = 1'b0;
            prev_err = 1'b0;
            if (s_tvalid && s_tready) begin
                logic lst;
                lst = 1'b0;
                while (mdl_len_q.size() > 0 && mdl_len_q[0] == '0) void'(mdl_len_q.pop_front());
                if (mdl_len_q.size() == 0) begin
                    mdl_viol++;
                end else begin
                    mdl_sent += $countones(s_tkeep);
                    if (mdl_sent >= int'(mdl_len_q[0])) begin
                        lst      = 1'b1;
                        prev_err = (mdl_sent > int'(mdl_len_q[0]));
                        void'(mdl_len_q.pop_front());
                        mdl_sent = 0;
                    end
                end
                exp_q.push_back({s_tdata, s_tkeep, lst});
                acc_cyc_q.push_back(cyc);
                prev_acc  = 1'b1;
                prev_data = s_tdata;
            end
        end
    end

    task automatic sb_clear();
        obs_q.delete(); exp_q.delete(); obs_cyc_q.delete(); acc_cyc_q.delete();
        err_viol = 0; lat_viol = 0; stab_viol = 0; mdl_viol = 0; len_viol = 0; err_pulses = 0;
    endtask

    // Raise len_valid for one cycle once the queue has room (caller at posedge+1).
    task automatic push_len(input logic [LW-1:0] l);
        for (int i = 0; i < 1000; i++) begin
            if (len_ready) begin
                len = l;
                len_valid = 1'b1;
                @(posedge clk); #1;
                len_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        failures++;
        $display("FAIL push_len_timeout len_ready=%b required=1", len_ready);
    endtask

    // Present one beat and hold it until accepted (caller at posedge+1).
    task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] k);
        logic acc;
        s_tdata = d;
        s_tkeep = k;
        s_tvalid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk); #1;
            if (acc) begin
                s_tvalid = 1'b0;
                return;
            end
        end
        s_tvalid = 1'b0;
        failures++;
        $display("FAIL send_beat_timeout s_tready=%b required=1", s_tready);
    endtask

    task automatic drain();
        m_tready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_m_tvalid got=%b req=0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL rst_m_tlast got=%b req=0", m_tlast); end
        checks++; if (m_tdata !== '0) begin failures++; $display("FAIL rst_m_tdata got=%h req=0", m_tdata); end
        checks++; if (m_tkeep !== '0) begin failures++; $display("FAIL rst_m_tkeep got=%h req=0", m_tkeep); end
        checks++; if (s_tready !== 1'b0) begin failures++; $display("FAIL rst_s_tready got=%b req=0", s_tready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b req=0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b req=0", err); end
        checks++; if (len_ready !== 1'b1) begin failures++; $display("FAIL rst_len_ready got=%b req=1", len_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        sb_clear();
        push_len(24);
        for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 8'hFF);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy_hold got=%b req=1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_drop got=%b req=0", busy); end
        @(posedge clk); #1;
        checks++; if (acc_cyc_q.size() < 1 || acc_cyc_q[0] - push_cyc !== 2)
            begin failures++; $display("FAIL t1_load_latency got=%0d req=2", acc_cyc_q.size() ? acc_cyc_q[0] - push_cyc : -1); end
        checks++; if (obs_q.size() !== 3) begin failures++; $display("FAIL t1_count got=%0d req=3", obs_q.size()); end
        else begin
            checks++; if ({obs_q[0][0], obs_q[1][0], obs_q[2][0]} !== 3'b001)
                begin failures++; $display("FAIL t1_tlast got=%b req=001", {obs_q[0][0], obs_q[1][0], obs_q[2][0]}); end
        end
        checks++; if (err_pulses !== 0) begin failures++; $display("FAIL t1_err got=%0d req=0", err_pulses); end
        checks++; if (lat_viol !== 0) begin failures++; $display("FAIL t1_latency got=%0d req=0", lat_viol); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL t1_beat%0d got=%h req=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_short_tail();
        sb_clear();
        push_len(20);
        send_beat({$urandom, $urandom}, 8'hFF);
        send_beat({$urandom, $urandom}, 8'hFF);
        send_beat({$urandom, $urandom}, 8'h0F);
        drain();
        checks++; if (obs_q.size() !== 3) begin failures++; $display("FAIL t2_count got=%0d req=3", obs_q.size()); end
        else begin
            checks++; if ({obs_q[0][0], obs_q[1][0], obs_q[2][0]} !== 3'b001)
                begin failures++; $display("FAIL t2_tlast got=%b req=001", {obs_q[0][0], obs_q[1][0], obs_q[2][0]}); end
            checks++; if (obs_q[2][SW:1] !== 8'h0F) begin failures++; $display("FAIL t2_keep got=%h req=0f", obs_q[2][SW:1]); end
        end
        checks++; if (err_pulses + err_viol !== 0) begin failures++; $display("FAIL t2_err got=%0d req=0", err_pulses + err_viol); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL t2_beat%0d got=%h req=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        sb_clear();
        push_len(8);
        push_len(16);
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 8'hFF);
        drain();
        checks++; if (obs_q.size() !== 3) begin failures++; $display("FAIL t3_count got=%0d req=3", obs_q.size()); end
        else begin
            checks++; if ({obs_q[0][0], obs_q[1][0], obs_q[2][0]} !== 3'b101)
                begin failures++; $display("FAIL t3_tlast got=%b req=101", {obs_q[0][0], obs_q[1][0], obs_q[2][0]}); end
            checks++; if (obs_cyc_q[2] - obs_cyc_q[0] !== 2)
                begin failures++; $display("FAIL t3_bubble got=%0d req=2", obs_cyc_q[2] - obs_cyc_q[0]); end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL t3_beat%0d got=%h req=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_len();
        sb_clear();
        push_len(0);
        push_len(8);
        send_beat({$urandom, $urandom}, 8'hFF);
        drain();
        checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL t4_count got=%0d req=1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0][0] !== 1'b1) begin failures++; $display("FAIL t4_tlast got=%b req=1", obs_q[0][0]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t4_idle_busy got=%b req=0", busy); end
    endtask

    task automatic test_overrun();
        sb_clear();
        push_len(4);
        push_len(16);
        for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 8'hFF);
        drain();
        checks++; if (err_pulses !== 1) begin failures++; $display("FAIL t5_err_pulses got=%0d req=1", err_pulses); end
        checks++; if (err_viol !== 0) begin failures++; $display("FAIL t5_err_timing got=%0d req=0", err_viol); end
        checks++; if (obs_q.size() !== 3) begin failures++; $display("FAIL t5_count got=%0d req=3", obs_q.size()); end
        else begin
            checks++; if ({obs_q[0][0], obs_q[1][0], obs_q[2][0]} !== 3'b101)
                begin failures++; $display("FAIL t5_tlast got=%b req=101", {obs_q[0][0], obs_q[1][0], obs_q[2][0]}); end
        end
    endtask

    task automatic test_backpressure_reset();
        int stall_bad;
        sb_clear();
        m_tready = 1'b0;
        push_len(24);
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) push_len(8);
        checks++; if (len_ready !== 1'b0) begin failures++; $display("FAIL t6_len_full got=%b req=0", len_ready); end
        send_beat({$urandom, $urandom}, 8'hFF);
        s_tdata = {$urandom, $urandom};
        s_tkeep = 8'hFF;
        s_tvalid = 1'b1;
        stall_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_tready !== 1'b0 || m_tvalid !== 1'b1) stall_bad++;
        end
        checks++; if (stall_bad !== 0) begin failures++; $display("FAIL t6_stall got=%0d req=0", stall_bad); end
        @(posedge clk); #1;
        m_tready = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        @(negedge clk);
        checks++; if (obs_q.size() !== 1 || exp_q.size() !== 2)
            begin failures++; $display("FAIL t6_count got=%0d/%0d req=1/2", obs_q.size(), exp_q.size()); end
        else begin
            checks++; if (obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL t6_beat0 got=%h req=%h", obs_q[0], exp_q[0]); end
        end
        checks++; if (stab_viol + lat_viol + mdl_viol + len_viol !== 0)
            begin failures++; $display("FAIL t6_protocol got=%0d req=0", stab_viol + lat_viol + mdl_viol + len_viol); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL t6_rst_m_tvalid got=%b req=0", m_tvalid); end
        checks++; if (len_ready !== 1'b1) begin failures++; $display("FAIL t6_rst_len_ready got=%b req=1", len_ready); end
        checks++; if (busy !== 1'b0 || s_tready !== 1'b0)
            begin failures++; $display("FAIL t6_rst_idle got=%b%b req=00", busy, s_tready); end
        @(negedge clk);
        rst_n = 1'b1;
        m_tready = 1'b1;
        @(posedge clk); #1;
        sb_clear();
        push_len(8);
        send_beat({$urandom, $urandom}, 8'hFF);
        drain();
        checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL t6_after_rst_count got=%0d req=1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0][0] !== 1'b1) begin failures++; $display("FAIL t6_after_rst_tlast got=%b req=1", obs_q[0][0]); end
        end
    endtask

    task automatic test_random();
        logic [LW-1:0] lens[$];
        logic [DW-1:0] bdata[$];
        logic [SW-1:0] bkeep[$];
        int nonzero;
        int lasts;
        bit done;
        sb_clear();
        nonzero = 0;
        for (int t = 0; t < 30; t++) begin
            int l, r;
            l = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40);
            lens.push_back(LW'(l));
            if (l != 0) nonzero++;
            r = l;
            while (r > 0) begin
                logic [SW-1:0] k;
                k = SW'($urandom);
                bdata.push_back({$urandom, $urandom});
                bkeep.push_back(k);
                r -= ($countones(k) < r) ? $countones(k) : r;
            end
        end
        done = 1'b0;
        fork
            begin
                fork
                    begin foreach (lens[i]) push_len(lens[i]); end
                    begin foreach (bdata[i]) send_beat(bdata[i], bkeep[i]); end
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_tready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        drain();
        checks++; if (obs_q.size() !== bdata.size())
            begin failures++; $display("FAIL rnd_count got=%0d req=%0d", obs_q.size(), bdata.size()); end
        checks++; if (exp_q.size() !== bdata.size())
            begin failures++; $display("FAIL rnd_accepted got=%0d req=%0d", exp_q.size(), bdata.size()); end
        lasts = 0;
        foreach (obs_q[i]) if (obs_q[i][0]) lasts++;
        checks++; if (lasts !== nonzero) begin failures++; $display("FAIL rnd_packets got=%0d req=%0d", lasts, nonzero); end
        checks++; if (err_viol + lat_viol + stab_viol + mdl_viol + len_viol !== 0)
            begin failures++; $display("FAIL rnd_protocol err=%0d lat=%0d stab=%0d mdl=%0d len=%0d req=0",
                                       err_viol, lat_viol, stab_viol, mdl_viol, len_viol); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_beat%0d got=%h req=%h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_idle_busy got=%b req=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_short_tail();
        test_back_to_back();
        test_zero_len();
        test_overrun();
        test_backpressure_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
